// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl_pkg
// Brief   : Shared pipeline definitions: hazard FSM state codes, zero register.
// Revision: 1.0
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam logic [4:0] REG_X0   = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module  : load_use_detect
// Brief   : Flags a decode-stage read of a register still being loaded in execute.
// Revision: 1.0
// ============================================================================
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_use_rs1,
  input  logic       ifid_use_rs2,
  input  logic [4:0] idex_rd,
  input  logic       idex_mem_read,
  output logic       hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = ifid_use_rs1 && (idex_rd == ifid_rs1);
  assign w_rs2_hit = ifid_use_rs2 && (idex_rd == ifid_rs2);

  // x0 is hardwired zero, so a load targeting it never produces a dependency
  assign hazard = idex_mem_read && (idex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush/freeze control for an in-order pipeline, with counters.
// Revision: 1.0
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_use_rs1,
  input  logic        ifid_use_rs2,
  input  logic [4:0]  idex_rd,
  input  logic        idex_mem_read,
  input  logic        ex_mispredict,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        pc_redirect,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic        mem_timeout_err
);

  localparam logic [2:0]  c_flush_load = FLUSH_CYCLES[2:0];
  localparam logic [15:0] c_timeout    = MEM_TIMEOUT[15:0];

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [2:0]  r_residual;
  logic [2:0]  w_next_residual;
  logic [15:0] r_wait_cnt;
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;
  logic        r_timeout_err;
  logic        w_freeze;
  logic        w_in_flush;
  logic        w_load_use;

  load_use_detect u_load_use_detect (
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_use_rs1  (ifid_use_rs1),
    .ifid_use_rs2  (ifid_use_rs2),
    .idex_rd       (idex_rd),
    .idex_mem_read (idex_mem_read),
    .hazard        (w_load_use)
  );

  assign w_freeze = dmem_req && !dmem_ready;
  // A freeze taken mid-flush parks in MEM_WAIT with the residual intact
  assign w_in_flush = (r_residual != 3'd0) && ((r_state == FLUSH) || (r_state == MEM_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_residual <= 3'd0;
    end else begin
      r_state    <= w_next_state;
      r_residual <= w_next_residual;
    end
  end

  always_comb begin
    w_next_state    = RUN;
    w_next_residual = r_residual;
    if (w_freeze) begin
      w_next_state = MEM_WAIT;
    end else if (ex_mispredict) begin
      w_next_residual = c_flush_load;
      w_next_state    = (c_flush_load != 3'd0) ? FLUSH : RUN;
    end else if (w_in_flush) begin
      w_next_residual = r_residual - 3'd1;
      w_next_state    = (r_residual == 3'd1) ? RUN : FLUSH;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    if (w_freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (ex_mispredict) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (w_in_flush) begin
      ifid_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= 16'd0;
      r_timeout_err <= 1'b0;
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (w_freeze) begin
        if (r_wait_cnt != c_timeout) begin
          r_wait_cnt <= r_wait_cnt + 16'd1;
        end
        if ((r_wait_cnt + 16'd1) == c_timeout) begin
          r_timeout_err <= 1'b1;
        end
      end else begin
        r_wait_cnt <= 16'd0;
      end
      if (!pc_en) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (pc_redirect) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_count     = r_stall_count;
  assign flush_count     = r_flush_count;
  assign mem_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=3).
// Revision: 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

  // {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
  localparam logic [6:0] NORM  = 7'b1010101;
  localparam logic [6:0] STALL = 7'b0000111;
  localparam logic [6:0] FRZ   = 7'b0000000;
  localparam logic [6:0] REDIR = 7'b1111111;
  localparam logic [6:0] FLSH  = 7'b1011101;

  typedef struct {
    string      tag;
    logic [6:0] ctrl;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic        ifid_use_rs1 = 1'b0, ifid_use_rs2 = 1'b0, idex_mem_read = 1'b0;
  logic        ex_mispredict = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic        pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic [31:0] stall_count, flush_count;
  logic        mem_timeout_err;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .ifid_rs1        (ifid_rs1),
    .ifid_rs2        (ifid_rs2),
    .ifid_use_rs1    (ifid_use_rs1),
    .ifid_use_rs2    (ifid_use_rs2),
    .idex_rd         (idex_rd),
    .idex_mem_read   (idex_mem_read),
    .ex_mispredict   (ex_mispredict),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .pc_redirect     (pc_redirect),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_flush      (idex_flush),
    .exmem_en        (exmem_en),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .mem_timeout_err (mem_timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_pop();
    exp_t       e;
    logic [6:0] obs;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e   = sb.pop_front();
    obs = {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};
    n_checks++;
    assert (obs === e.ctrl) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed=%b expected=%b", e.tag, obs, e.ctrl);
    end
    n_checks++;
    assert (stall_count === exp_stall) else begin
      n_fail++;
      $error("FAIL %s stall_count: observed=%0d expected=%0d", e.tag, stall_count, exp_stall);
    end
    n_checks++;
    assert (flush_count === exp_flush) else begin
      n_fail++;
      $error("FAIL %s flush_count: observed=%0d expected=%0d", e.tag, flush_count, exp_flush);
    end
    n_checks++;
    assert (mem_timeout_err === e.err) else begin
      n_fail++;
      $error("FAIL %s mem_timeout_err: observed=%b expected=%b", e.tag, mem_timeout_err, e.err);
    end
    if (!e.ctrl[6]) exp_stall = exp_stall + 32'd1;
    if (e.ctrl[5])  exp_flush = exp_flush + 32'd1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic mp, input logic rq, input logic rdy);
    idex_mem_read = mr;  idex_rd = rd;  ifid_rs1 = rs1;  ifid_rs2 = rs2;
    ifid_use_rs1  = u1;  ifid_use_rs2 = u2;
    ex_mispredict = mp;  dmem_req = rq;  dmem_ready = rdy;
  endtask

  task automatic step(input string tag, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                      input logic u2, input logic mp, input logic rq, input logic rdy,
                      input logic [6:0] ctrl, input logic err);
    @(posedge clk);
    #1;
    drive(mr, rd, rs1, rs2, u1, u2, mp, rq, rdy);
    sb.push_back('{tag, ctrl, err});
    @(negedge clk);
    check_pop();
  endtask

  initial begin
    // reset state, before and across clock edges
    #3;
    sb.push_back('{"rst_t0", NORM, 1'b0});
    check_pop();
    repeat (2) @(negedge clk);
    sb.push_back('{"rst_held", NORM, 1'b0});
    check_pop();
    rst = 1'b0;

    step("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0);
    step("lu_rs2",      1, 5, 0, 5, 0, 1, 0, 0, 1, STALL, 0);
    step("lu_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0);
    step("x0_exempt",   1, 0, 0, 5, 1, 1, 0, 0, 1, NORM,  0);
    step("no_use",      1, 7, 7, 0, 0, 0, 0, 0, 0, NORM,  0);
    step("lu_rs1",      1, 7, 7, 0, 1, 0, 0, 0, 0, STALL, 0);
    step("rs_miss",     1, 7, 6, 8, 1, 1, 0, 0, 0, NORM,  0);
    step("not_load",    0, 7, 7, 7, 1, 1, 0, 0, 0, NORM,  0);

    step("redir",       0, 0, 0, 0, 0, 0, 1, 0, 0, REDIR, 0);
    step("fl1",         0, 0, 0, 0, 0, 0, 0, 0, 0, FLSH,  0);
    step("fl2",         0, 0, 0, 0, 0, 0, 0, 0, 0, FLSH,  0);
    step("fl_done",     0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0);

    step("redir_a",     0, 0, 0, 0, 0, 0, 1, 0, 0, REDIR, 0);
    step("fl_lu_supp",  1, 5, 5, 0, 1, 0, 0, 0, 0, FLSH,  0);
    step("redir_in_fl", 0, 0, 0, 0, 0, 0, 1, 0, 0, REDIR, 0);
    step("fl_b1",       0, 0, 0, 0, 0, 0, 0, 0, 0, FLSH,  0);
    step("fl_b2",       0, 0, 0, 0, 0, 0, 0, 0, 0, FLSH,  0);
    step("fl_b_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0);

    step("redir_c",     0, 0, 0, 0, 0, 0, 1, 0, 0, REDIR, 0);
    step("fl_c1",       0, 0, 0, 0, 0, 0, 0, 0, 0, FLSH,  0);
    step("frz_in_fl",   0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,   0);
    step("fl_c_resume", 0, 0, 0, 0, 0, 0, 0, 1, 1, FLSH,  0);
    step("fl_c_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0);

    step("frz_lu",      1, 5, 5, 0, 1, 0, 0, 1, 0, FRZ,   0);
    step("wait_rdy_lu", 1, 5, 5, 0, 1, 0, 0, 1, 1, STALL, 0);
    step("post_lu",     0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0);

    // held redirect under a 4-cycle freeze; timeout hits on the third frozen cycle
    step("frz_p1",      0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,   0);
    step("frz_p2",      0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,   0);
    step("frz_p3",      0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,   0);
    step("frz_p4",      0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,   1);
    step("redir_rel",   0, 0, 0, 0, 0, 0, 1, 1, 1, REDIR, 1);
    step("fl_p1",       0, 0, 0, 0, 0, 0, 0, 0, 0, FLSH,  1);
    step("fl_p2",       0, 0, 0, 0, 0, 0, 0, 0, 0, FLSH,  1);
    step("err_sticky",  0, 0, 0, 0, 0, 0, 0, 1, 1, NORM,  1);

    // asynchronous reset landing between edges in the middle of FLUSH
    step("redir_d",     0, 0, 0, 0, 0, 0, 1, 0, 0, REDIR, 1);
    @(posedge clk);
    #2;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    sb.push_back('{"async_rst", NORM, 1'b0});
    check_pop();
    @(negedge clk);
    rst = 1'b0;
    step("post_rst",    0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0);
    step("post_rst2",   0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
